// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package muldiv_unit_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = XLEN;
    localparam int CNT_W = $clog2(ITERS) + 1;

    // M-extension alucontrol codes, next to the existing ALU codes
    localparam logic [4:0] ALU_MUL    = 5'b11000;
    localparam logic [4:0] ALU_MULH   = 5'b11001;
    localparam logic [4:0] ALU_MULHSU = 5'b11010;
    localparam logic [4:0] ALU_MULHU  = 5'b11011;
    localparam logic [4:0] ALU_DIV    = 5'b11100;
    localparam logic [4:0] ALU_DIVU   = 5'b11101;
    localparam logic [4:0] ALU_REM    = 5'b11110;
    localparam logic [4:0] ALU_REMU   = 5'b10111;
    localparam logic [4:0] ALU_LUI    = 5'b11111;
    localparam logic [4:0] ALU_BNE    = 5'b10000;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CALC   = 2'b01,
        FINISH = 2'b10
    } state_t;

    // Per-opcode properties: sel_hi picks the product high half for multiplies
    // and the remainder (held in the high word) for divides.
    typedef struct packed {
        logic is_m;
        logic is_div;
        logic sign_a;
        logic sign_b;
        logic sel_hi;
        logic rem_sign;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [4:0] code);
        op_info_t d;
        d = '0;
        case (code)
            ALU_MUL:    d = '{is_m: 1'b1, is_div: 1'b0, sign_a: 1'b1, sign_b: 1'b1, sel_hi: 1'b0, rem_sign: 1'b0};
            ALU_MULH:   d = '{is_m: 1'b1, is_div: 1'b0, sign_a: 1'b1, sign_b: 1'b1, sel_hi: 1'b1, rem_sign: 1'b0};
            ALU_MULHSU: d = '{is_m: 1'b1, is_div: 1'b0, sign_a: 1'b1, sign_b: 1'b0, sel_hi: 1'b1, rem_sign: 1'b0};
            ALU_MULHU:  d = '{is_m: 1'b1, is_div: 1'b0, sign_a: 1'b0, sign_b: 1'b0, sel_hi: 1'b1, rem_sign: 1'b0};
            ALU_DIV:    d = '{is_m: 1'b1, is_div: 1'b1, sign_a: 1'b1, sign_b: 1'b1, sel_hi: 1'b0, rem_sign: 1'b0};
            ALU_DIVU:   d = '{is_m: 1'b1, is_div: 1'b1, sign_a: 1'b0, sign_b: 1'b0, sel_hi: 1'b0, rem_sign: 1'b0};
            ALU_REM:    d = '{is_m: 1'b1, is_div: 1'b1, sign_a: 1'b1, sign_b: 1'b1, sel_hi: 1'b1, rem_sign: 1'b1};
            ALU_REMU:   d = '{is_m: 1'b1, is_div: 1'b1, sign_a: 1'b0, sign_b: 1'b0, sel_hi: 1'b1, rem_sign: 1'b1};
            default:    d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline and the muldiv unit.
// Latency: n/a (wires only).
// Backpressure: the unit holds the pipeline through stall_e while busy.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic            start_e;
    logic            flush_e;
    logic [4:0]      alucontrol_e;
    logic [XLEN-1:0] srca_e;
    logic [XLEN-1:0] srcb_e;
    logic            busy;
    logic            stall_e;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start_e, flush_e, alucontrol_e, srca_e, srcb_e,
        input  busy, stall_e, done, result
    );

    modport slave (
        input  start_e, flush_e, alucontrol_e, srca_e, srcb_e,
        output busy, stall_e, done, result
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// One iteration step: shift-add multiply or restoring shift-subtract divide.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the step.
module muldiv_iter_core
    import muldiv_unit_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    // Multiply: add multiplicand when multiplier LSB is set, then shift {carry,hi,lo} right.
    // Divide: shift {hi,lo} left, subtract divisor from the 33-bit partial remainder if it fits.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        fits    = (shifted >= {1'b0, opnd});
        hi_next = '0;
        lo_next = '0;
        if (is_div) begin
            hi_next = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], fits};
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide; MULDIV_FAST_MUL_EN selects a single-cycle '*' for MUL*.
// Latency: done 34 cycles after start (1 cycle for divide-by-zero, or fast multiplies).
// Backpressure: stall_e holds the pipeline while busy & ~done; start_e while busy is ignored.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  opnd;
    logic             op_div;
    logic             op_neg;
    logic             op_sel_hi;
    logic             busy_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;

    op_info_t         dec;
    logic             a_neg;
    logic             b_neg;
    logic             res_neg;
    logic             div_zero;
    logic             accept;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic [XLEN-1:0]  step_hi;
    logic [XLEN-1:0]  step_lo;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]  quo_rem;
    logic [XLEN-1:0]  fixed_res;

    // Decode the incoming op, derive operand magnitudes and the final result sign.
    always_comb begin
        dec      = decode_op(bus.alucontrol_e);
        a_neg    = dec.sign_a & bus.srca_e[XLEN-1];
        b_neg    = dec.sign_b & bus.srcb_e[XLEN-1];
        res_neg  = dec.rem_sign ? a_neg : (a_neg ^ b_neg);
        mag_a    = a_neg ? (-bus.srca_e) : bus.srca_e;
        mag_b    = b_neg ? (-bus.srcb_e) : bus.srcb_e;
        div_zero = dec.is_div & (bus.srcb_e == '0);
        accept   = bus.start_e & dec.is_m & ~busy_q;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN-1:0] fast_p;
    logic [XLEN-1:0]          fast_res;

    // Single-cycle product: operands extended by one bit so signed/unsigned share one multiplier.
    always_comb begin
        fast_a   = {dec.sign_a & bus.srca_e[XLEN-1], bus.srca_e};
        fast_b   = {dec.sign_b & bus.srcb_e[XLEN-1], bus.srcb_e};
        fast_p   = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
        fast_res = dec.sel_hi ? fast_p[2*XLEN-1:XLEN] : fast_p[XLEN-1:0];
    end
`endif

    muldiv_iter_core u_iter (
        .is_div  (op_div),
        .hi      (acc_hi),
        .lo      (acc_lo),
        .opnd    (opnd),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // Sign fix: products are negated as a full 64-bit value, quotient/remainder per word.
    always_comb begin
        prod_s    = op_neg ? (-{acc_hi, acc_lo}) : {acc_hi, acc_lo};
        quo_rem   = op_sel_hi ? acc_hi : acc_lo;
        fixed_res = '0;
        if (op_div) begin
            fixed_res = op_neg ? (-quo_rem) : quo_rem;
        end else begin
            fixed_res = op_sel_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
    end

    // Control FSM. busy stays high through the done cycle, so a start presented alongside
    // done is dropped; on the direct path done is already set when FINISH is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            op_div    <= 1'b0;
            op_neg    <= 1'b0;
            op_sel_hi <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else if (bus.flush_e) begin
            state  <= IDLE;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (accept) begin
                        busy_q    <= 1'b1;
                        count     <= '0;
                        op_div    <= dec.is_div;
                        op_neg    <= res_neg;
                        op_sel_hi <= dec.sel_hi;
                        acc_hi    <= '0;
                        if (div_zero) begin
                            result_q <= dec.sel_hi ? bus.srca_e : '1;
                            done_q   <= 1'b1;
                            state    <= FINISH;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!dec.is_div) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state    <= FINISH;
                        end
`endif
                        else begin
                            acc_lo <= dec.is_div ? mag_a : mag_b;
                            opnd   <= dec.is_div ? mag_b : mag_a;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (done_q) begin
                        done_q <= 1'b0;
                        busy_q <= 1'b0;
                    end else begin
                        result_q <= fixed_res;
                        done_q   <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.stall_e = busy_q & ~done_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, corner sequences, randomized ops.
// Latency: expected done cycle derived from op class and divisor.
// Backpressure: stall_e checked high on every busy cycle before done.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    muldiv_unit_if bus();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural reference computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint          p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (code)
            ALU_MUL:    begin p = sa * sb;            return p[31:0];   end
            ALU_MULH:   begin p = sa * sb;            return p[63:32];  end
            ALU_MULHSU: begin p = sa * longint'(ub);  return p[63:32];  end
            ALU_MULHU:  begin up = ua * ub;           return up[63:32]; end
            ALU_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            ALU_REM:    begin if (b == 0) return a;             p = sa % sb; return p[31:0]; end
            ALU_DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; up = ua / ub; return up[31:0]; end
            ALU_REMU:   begin if (b == 0) return a;             up = ua % ub; return up[31:0]; end
            default:    return 32'h0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [4:0] code, input logic [31:0] b);
        bit is_div;
        is_div = (code == ALU_DIV) || (code == ALU_DIVU) || (code == ALU_REM) || (code == ALU_REMU);
        if (is_div && b == 0) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) return 1;
`endif
        return 34;
    endfunction

    // Issue one op, watch it to completion; optionally pulse a stray start at poke_at.
    task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name, input int poke_at);
        int lat;
        int el;
        bit stall_ok;
        el = exp_lat(code, b);
        bus.alucontrol_e = code;
        bus.srca_e       = a;
        bus.srcb_e       = b;
        bus.start_e      = 1'b1;
        tick();
        bus.start_e = 1'b0;
        lat      = 0;
        stall_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            if (!(bus.busy && bus.stall_e)) stall_ok = 1'b0;
            if (c == poke_at) begin
                bus.alucontrol_e = ALU_MUL;
                bus.srca_e       = $urandom;
                bus.srcb_e       = $urandom;
                bus.start_e      = 1'b1;
            end
            tick();
            bus.start_e = 1'b0;
        end
        check({name, " latency"}, 32'(lat), 32'(el));
        check({name, " result"}, bus.result, exp);
        check({name, " stall_before_done"}, {31'b0, stall_ok}, 32'd1);
        check({name, " busy_at_done"}, {31'b0, bus.busy}, 32'd1);
        check({name, " stall_at_done"}, {31'b0, bus.stall_e}, 32'd0);
        tick();
        check({name, " done_pulse_end"}, {31'b0, bus.done}, 32'd0);
        check({name, " busy_end"}, {31'b0, bus.busy}, 32'd0);
        check({name, " result_hold"}, bus.result, exp);
    endtask

    logic [4:0]  codes[8];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rc;
    logic [31:0] prev;

    initial begin
        vecs[0]  = '{ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2]  = '{ALU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
        vecs[3]  = '{ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
        vecs[4]  = '{ALU_DIV,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA};
        vecs[5]  = '{ALU_REM,    32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE};
        vecs[6]  = '{ALU_DIVU,   32'd20,         32'd3,         32'd6};
        vecs[7]  = '{ALU_REMU,   32'd20,         32'd3,         32'd2};
        vecs[8]  = '{ALU_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{ALU_REM,    32'd5,          32'd0,         32'd5};
        vecs[10] = '{ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
        vecs[12] = '{ALU_DIVU,   32'd7,          32'd0,         32'hFFFF_FFFF};
        vecs[13] = '{ALU_REMU,   32'd7,          32'd0,         32'd7};
        codes = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

        reset            = 1'b1;
        bus.start_e      = 1'b0;
        bus.flush_e      = 1'b0;
        bus.alucontrol_e = '0;
        bus.srca_e       = '0;
        bus.srcb_e       = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy",    {31'b0, bus.busy},    32'd0);
        check("reset stall",   {31'b0, bus.stall_e}, 32'd0);
        check("reset done",    {31'b0, bus.done},    32'd0);
        check("reset result",  bus.result,           32'd0);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i), -1);
        end

        // Non-M codes are ignored
        bus.alucontrol_e = ALU_LUI;
        bus.srca_e       = 32'd9;
        bus.srcb_e       = 32'd9;
        bus.start_e      = 1'b1;
        tick();
        bus.alucontrol_e = ALU_BNE;
        tick();
        bus.start_e = 1'b0;
        check("non_m busy",  {31'b0, bus.busy}, 32'd0);
        check("non_m done",  {31'b0, bus.done}, 32'd0);
        tick();
        check("non_m busy_late", {31'b0, bus.busy}, 32'd0);

        // Flush at cycle 10 of a DIV, then a new MUL started at cycle 12
        prev             = bus.result;
        bus.alucontrol_e = ALU_DIV;
        bus.srca_e       = 32'd1000;
        bus.srcb_e       = 32'd7;
        bus.start_e      = 1'b1;
        tick();
        bus.start_e = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("flush pre busy", {31'b0, bus.busy}, 32'd1);
        bus.flush_e = 1'b1;
        tick();
        bus.flush_e = 1'b0;
        check("flush busy",   {31'b0, bus.busy},    32'd0);
        check("flush stall",  {31'b0, bus.stall_e}, 32'd0);
        check("flush done",   {31'b0, bus.done},    32'd0);
        check("flush result_hold", bus.result, prev);
        tick();
        check("flush done_c12", {31'b0, bus.done}, 32'd0);
        run_op(ALU_MUL, 32'd12345, 32'd678, ref_model(ALU_MUL, 32'd12345, 32'd678), "post_flush_mul", -1);

        // Flush wins over start in the same cycle
        bus.alucontrol_e = ALU_MUL;
        bus.start_e      = 1'b1;
        bus.flush_e      = 1'b1;
        tick();
        bus.start_e = 1'b0;
        bus.flush_e = 1'b0;
        check("flush_prio busy", {31'b0, bus.busy}, 32'd0);

        // Stray start during CALC does not disturb the running divide
        run_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, "poke_divu", 5);

        // Reset at cycle 20 of a MUL
        bus.alucontrol_e = ALU_MUL;
        bus.srca_e       = 32'd3;
        bus.srcb_e       = 32'd5;
        bus.start_e      = 1'b1;
        tick();
        bus.start_e = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset busy",   {31'b0, bus.busy},    32'd0);
        check("mid_reset stall",  {31'b0, bus.stall_e}, 32'd0);
        check("mid_reset done",   {31'b0, bus.done},    32'd0);
        check("mid_reset result", bus.result,           32'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rc = codes[$urandom_range(0, 7)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
                default: ;
            endcase
            run_op(rc, ra, rb, ref_model(rc, ra, rb), $sformatf("rand%0d", i), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
